// File: rtl/regfile_mp_sb.sv
// Multi-port integer register file with two write ports, optional write-to-read
// bypass and a per-register busy scoreboard for long-latency results.
module regfile_mp_sb #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NRD      = 2,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr0_en,
  input  logic [ADDR_W-1:0]      wr0_idx,
  input  logic [DATA_W-1:0]      wr0_data,
  input  logic                   wr1_en,
  input  logic [ADDR_W-1:0]      wr1_idx,
  input  logic [DATA_W-1:0]      wr1_data,
  input  logic                   sb_set_en,
  input  logic [ADDR_W-1:0]      sb_set_idx,
  input  logic [NRD*ADDR_W-1:0]  rd_idx,
  output logic [NRD*DATA_W-1:0]  rd_data,
  output logic [NRD-1:0]         rd_busy,
  output logic [2**ADDR_W-1:0]   busy_vec
);

  localparam int NUM_REGS = 2**ADDR_W;

  logic [DATA_W-1:0]   regs [NUM_REGS];
  logic [NUM_REGS-1:0] busy_q;
  logic [NUM_REGS-1:0] busy_d;
  logic                wr0_ok;
  logic                wr1_ok;

  assign wr0_ok = wr0_en && !((ZERO_REG != 0) && (wr0_idx == '0));
  // wr1 loses to wr0 on an index collision
  assign wr1_ok = wr1_en && !((ZERO_REG != 0) && (wr1_idx == '0)) &&
                  !(wr0_en && (wr0_idx == wr1_idx));

  always_comb begin
    busy_d = busy_q;
    for (int k = 0; k < NUM_REGS; k++) begin
      if (sb_set_en && (sb_set_idx == ADDR_W'(k))) begin
        busy_d[k] = 1'b1;
      end else if (wr1_en && (wr1_idx == ADDR_W'(k))) begin
        busy_d[k] = 1'b0;
      end
    end
    if (ZERO_REG != 0) begin
      busy_d[0] = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int k = 0; k < NUM_REGS; k++) begin
        regs[k] <= '0;
      end
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
      if (wr0_ok) begin
        regs[wr0_idx] <= wr0_data;
      end
      if (wr1_ok) begin
        regs[wr1_idx] <= wr1_data;
      end
    end
  end

  assign busy_vec = busy_q;

  for (genvar i = 0; i < NRD; i++) begin : g_rd
    logic [ADDR_W-1:0] idx;
    logic [DATA_W-1:0] data;
    logic              busy;
    logic              hit0;
    logic              hit1;
    logic              is_zero;

    assign idx = rd_idx[i*ADDR_W +: ADDR_W];

    always_comb begin
      hit0    = wr0_en && (wr0_idx == idx);
      hit1    = wr1_en && (wr1_idx == idx);
      is_zero = (ZERO_REG != 0) && (idx == '0);
      data    = regs[idx];
      if (BYPASS != 0) begin
        if (hit0) begin
          data = wr0_data;
        end else if (hit1) begin
          data = wr1_data;
        end
        busy = busy_q[idx] && !hit1;
      end else begin
        busy = busy_q[idx] || hit1;
      end
      if (is_zero) begin
        data = '0;
        busy = 1'b0;
      end
    end

    assign rd_data[i*DATA_W +: DATA_W] = data;
    assign rd_busy[i]                  = busy;
  end

endmodule

// File: tb/tb_regfile_mp_sb.sv
// Scoreboard bench for regfile_mp_sb: one bypassing and one non-bypassing instance
// driven with the same stimulus, expected values queued as stimulus is applied.
module tb_regfile_mp_sb;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr0_en, wr1_en, sb_set_en;
  logic [4:0]  wr0_idx, wr1_idx, sb_set_idx;
  logic [31:0] wr0_data, wr1_data;
  logic [9:0]  rd_idx;
  logic [63:0] rd_data_b, rd_data_n;
  logic [1:0]  rd_busy_b, rd_busy_n;
  logic [31:0] busy_vec_b, busy_vec_n;

  int total = 0;
  int bad = 0;
  logic [31:0] exp_q[$];
  logic [31:0] exp;

  always #5 clk = ~clk;

  regfile_mp_sb #(.DATA_W(32), .ADDR_W(5), .NRD(2), .BYPASS(1), .ZERO_REG(1)) u_byp (
    .clk(clk), .rst(rst),
    .wr0_en(wr0_en), .wr0_idx(wr0_idx), .wr0_data(wr0_data),
    .wr1_en(wr1_en), .wr1_idx(wr1_idx), .wr1_data(wr1_data),
    .sb_set_en(sb_set_en), .sb_set_idx(sb_set_idx),
    .rd_idx(rd_idx), .rd_data(rd_data_b), .rd_busy(rd_busy_b), .busy_vec(busy_vec_b));

  regfile_mp_sb #(.DATA_W(32), .ADDR_W(5), .NRD(2), .BYPASS(0), .ZERO_REG(1)) u_nob (
    .clk(clk), .rst(rst),
    .wr0_en(wr0_en), .wr0_idx(wr0_idx), .wr0_data(wr0_data),
    .wr1_en(wr1_en), .wr1_idx(wr1_idx), .wr1_data(wr1_data),
    .sb_set_en(sb_set_en), .sb_set_idx(sb_set_idx),
    .rd_idx(rd_idx), .rd_data(rd_data_n), .rd_busy(rd_busy_n), .busy_vec(busy_vec_n));

  // inputs change 1 time unit after the rising edge, outputs sampled 2 units later
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wr0_en = 0; wr1_en = 0; sb_set_en = 0;
    wr0_idx = 0; wr1_idx = 0; sb_set_idx = 0;
    wr0_data = 0; wr1_data = 0;
  endtask

  task automatic test_reset();
    rst = 0;
    idle();
    rd_idx = 0;
    tick();
    tick();
    rst = 1;
    for (int i = 0; i < 32; i++) begin
      rd_idx = {5'(31 - i), 5'(i)};
      exp_q.push_back(32'h0);
      #2;
      exp = exp_q.pop_front();
      total++;
      if (rd_data_b !== {exp, exp} || rd_data_n !== {exp, exp} ||
          rd_busy_b !== 2'b00 || rd_busy_n !== 2'b00) begin
        bad++;
        $display("FAIL reset_read idx=%0d got byp=%h/%b nob=%h/%b want data=0 busy=0",
                 i, rd_data_b, rd_busy_b, rd_data_n, rd_busy_n);
      end
    end
    total++;
    if (busy_vec_b !== 32'h0 || busy_vec_n !== 32'h0) begin
      bad++;
      $display("FAIL reset_busy_vec got %h/%h want 0", busy_vec_b, busy_vec_n);
    end
    tick();
  endtask

  task automatic test_bypass();
    wr0_en = 1; wr0_idx = 5; wr0_data = 32'hDEADBEEF;
    rd_idx = {5'd0, 5'd5};
    exp_q.push_back(32'hDEADBEEF);
    exp_q.push_back(32'h0);
    #2;
    exp = exp_q.pop_front();
    total++;
    if (rd_data_b[31:0] !== exp) begin
      bad++;
      $display("FAIL bypass_same_cycle got %h want %h", rd_data_b[31:0], exp);
    end
    exp = exp_q.pop_front();
    total++;
    if (rd_data_n[31:0] !== exp) begin
      bad++;
      $display("FAIL nobypass_same_cycle got %h want %h", rd_data_n[31:0], exp);
    end
    tick();
    idle();
    exp_q.push_back(32'hDEADBEEF);
    #2;
    exp = exp_q.pop_front();
    total++;
    if (rd_data_b[31:0] !== exp || rd_data_n[31:0] !== exp) begin
      bad++;
      $display("FAIL write_next_cycle got %h/%h want %h", rd_data_b[31:0], rd_data_n[31:0], exp);
    end
    tick();
  endtask

  task automatic test_arbitration();
    wr0_en = 1; wr0_idx = 7; wr0_data = 32'h11;
    wr1_en = 1; wr1_idx = 7; wr1_data = 32'h22;
    rd_idx = {5'd0, 5'd7};
    exp_q.push_back(32'h11);
    #2;
    exp = exp_q.pop_front();
    total++;
    if (rd_data_b[31:0] !== exp) begin
      bad++;
      $display("FAIL collide_bypass got %h want %h", rd_data_b[31:0], exp);
    end
    tick();
    idle();
    exp_q.push_back(32'h11);
    #2;
    exp = exp_q.pop_front();
    total++;
    if (rd_data_b[31:0] !== exp || rd_data_n[31:0] !== exp) begin
      bad++;
      $display("FAIL collide_stored got %h/%h want %h", rd_data_b[31:0], rd_data_n[31:0], exp);
    end
    // writes to x0 through both ports must vanish
    wr0_en = 1; wr0_idx = 0; wr0_data = 32'h33;
    wr1_en = 1; wr1_idx = 0; wr1_data = 32'h44;
    rd_idx = {5'd0, 5'd0};
    exp_q.push_back(32'h0);
    #2;
    exp = exp_q.pop_front();
    total++;
    if (rd_data_b !== {exp, exp}) begin
      bad++;
      $display("FAIL x0_bypass got %h want 0", rd_data_b);
    end
    tick();
    idle();
    exp_q.push_back(32'h0);
    #2;
    exp = exp_q.pop_front();
    total++;
    if (rd_data_b[31:0] !== exp || rd_data_n[31:0] !== exp) begin
      bad++;
      $display("FAIL x0_stored got %h/%h want 0", rd_data_b[31:0], rd_data_n[31:0]);
    end
    // distinct indices on both ports, read back on both read ports
    wr0_en = 1; wr0_idx = 1; wr0_data = 32'hA0A0;
    wr1_en = 1; wr1_idx = 2; wr1_data = 32'hB0B0;
    tick();
    idle();
    rd_idx = {5'd2, 5'd1};
    exp_q.push_back(32'hA0A0);
    exp_q.push_back(32'hB0B0);
    #2;
    exp = exp_q.pop_front();
    total++;
    if (rd_data_n[31:0] !== exp) begin
      bad++;
      $display("FAIL dual_write_p0 got %h want %h", rd_data_n[31:0], exp);
    end
    exp = exp_q.pop_front();
    total++;
    if (rd_data_n[63:32] !== exp || rd_data_b[63:32] !== exp) begin
      bad++;
      $display("FAIL dual_write_p1 got %h/%h want %h", rd_data_n[63:32], rd_data_b[63:32], exp);
    end
    tick();
  endtask

  task automatic test_scoreboard();
    sb_set_en = 1; sb_set_idx = 9;
    rd_idx = {5'd9, 5'd9};
    #2;
    total++;
    if (rd_busy_b !== 2'b00 || rd_busy_n !== 2'b00) begin
      bad++;
      $display("FAIL set_not_visible got %b/%b want 00", rd_busy_b, rd_busy_n);
    end
    tick();
    idle();
    #2;
    total++;
    if (rd_busy_b !== 2'b11 || rd_busy_n !== 2'b11 || busy_vec_b !== 32'h200) begin
      bad++;
      $display("FAIL set_visible got %b/%b vec=%h want 11 vec=200", rd_busy_b, rd_busy_n, busy_vec_b);
    end
    wr1_en = 1; wr1_idx = 9; wr1_data = 32'hCAFE;
    exp_q.push_back(32'hCAFE);
    exp_q.push_back(32'h0);
    #2;
    exp = exp_q.pop_front();
    total++;
    if (rd_busy_b[0] !== 1'b0 || rd_data_b[31:0] !== exp) begin
      bad++;
      $display("FAIL return_bypass got busy=%b data=%h want busy=0 data=%h", rd_busy_b[0], rd_data_b[31:0], exp);
    end
    exp = exp_q.pop_front();
    total++;
    if (rd_busy_n[0] !== 1'b1 || rd_data_n[31:0] !== exp) begin
      bad++;
      $display("FAIL return_nobypass got busy=%b data=%h want busy=1 data=%h", rd_busy_n[0], rd_data_n[31:0], exp);
    end
    tick();
    idle();
    exp_q.push_back(32'hCAFE);
    #2;
    exp = exp_q.pop_front();
    total++;
    if (busy_vec_b[9] !== 1'b0 || busy_vec_n[9] !== 1'b0 || rd_data_n[31:0] !== exp || rd_busy_n !== 2'b00) begin
      bad++;
      $display("FAIL clear_after_return got vec9=%b/%b data=%h busy=%b want 0/0 %h 00",
               busy_vec_b[9], busy_vec_n[9], rd_data_n[31:0], rd_busy_n, exp);
    end
    tick();
  endtask

  task automatic test_set_clear_same();
    sb_set_en = 1; sb_set_idx = 12;
    wr1_en = 1; wr1_idx = 12; wr1_data = 32'h77;
    tick();
    idle();
    #2;
    total++;
    if (busy_vec_b !== 32'h1000 || busy_vec_n !== 32'h1000) begin
      bad++;
      $display("FAIL set_wins got %h/%h want 00001000", busy_vec_b, busy_vec_n);
    end
    sb_set_en = 1; sb_set_idx = 0;
    tick();
    sb_set_idx = 12;
    #2;
    total++;
    if (busy_vec_b[0] !== 1'b0 || busy_vec_n[0] !== 1'b0) begin
      bad++;
      $display("FAIL x0_never_busy got %b/%b want 0", busy_vec_b[0], busy_vec_n[0]);
    end
    tick();
    idle();
    wr0_en = 1; wr0_idx = 12; wr0_data = 32'h99;
    #2;
    total++;
    if (busy_vec_b !== 32'h1000) begin
      bad++;
      $display("FAIL idempotent_set got %h want 00001000", busy_vec_b);
    end
    tick();
    idle();
    #2;
    total++;
    if (busy_vec_b !== 32'h1000 || busy_vec_n !== 32'h1000) begin
      bad++;
      $display("FAIL wr0_keeps_busy got %h/%h want 00001000", busy_vec_b, busy_vec_n);
    end
    wr1_en = 1; wr1_idx = 12; wr1_data = 32'h78;
    tick();
    idle();
    #2;
    total++;
    if (busy_vec_b !== 32'h0 || busy_vec_n !== 32'h0) begin
      bad++;
      $display("FAIL single_clear got %h/%h want 0", busy_vec_b, busy_vec_n);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    sb_set_en = 1; sb_set_idx = 3;
    tick();
    sb_set_idx = 4;
    wr0_en = 1; wr0_idx = 3; wr0_data = 32'h55;
    tick();
    idle();
    rd_idx = {5'd4, 5'd3};
    exp_q.push_back(32'h55);
    #2;
    exp = exp_q.pop_front();
    total++;
    if (busy_vec_b !== 32'h18 || rd_data_n[31:0] !== exp || rd_busy_n !== 2'b11) begin
      bad++;
      $display("FAIL pre_reset got vec=%h data=%h busy=%b want 18 %h 11", busy_vec_b, rd_data_n[31:0], rd_busy_n, exp);
    end
    rst = 0;
    wr0_en = 1; wr0_idx = 3; wr0_data = 32'hAA;
    sb_set_en = 1; sb_set_idx = 5;
    tick();
    rst = 1;
    idle();
    exp_q.push_back(32'h0);
    #2;
    exp = exp_q.pop_front();
    total++;
    if (rd_data_b[31:0] !== exp || rd_data_n[31:0] !== exp ||
        busy_vec_b !== 32'h0 || busy_vec_n !== 32'h0 || rd_busy_b !== 2'b00) begin
      bad++;
      $display("FAIL post_reset got data=%h/%h vec=%h/%h busy=%b want 0",
               rd_data_b[31:0], rd_data_n[31:0], busy_vec_b, busy_vec_n, rd_busy_b);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_bypass();
    test_arbitration();
    test_scoreboard();
    test_set_clear_same();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/regfile_mp_sb.md
Name: regfile_mp_sb

Overview:
- Parametrised successor to the CPU integer register file: configurable data width, depth and read-port count.
- Two write ports: wr0 for the in-order WB stage, wr1 for late returns from the load unit or multiply/divide unit.
- Optional same-cycle write-to-read bypass.
- Per-register busy scoreboard so decode can stall on outstanding long-latency results.

Parameters:
- DATA_W, 32, register width in bits.
- ADDR_W, 5, index width; NUM_REGS = 2**ADDR_W.
- NRD, 2, number of read ports (1..4).
- BYPASS, 1, 1 = same-cycle write data is forwarded to reads; 0 = reads return the stored value only.
- ZERO_REG, 1, 1 = register 0 is hardwired to zero and can never be busy.

Ports:
- clk, input, 1, clock; all state updates on the rising edge.
- rst, input, 1, synchronous active-low reset.
- wr0_en, input, 1, WB-stage write enable.
- wr0_idx, input, ADDR_W, WB-stage destination index.
- wr0_data, input, DATA_W, WB-stage write data.
- wr1_en, input, 1, late-return write enable.
- wr1_idx, input, ADDR_W, late-return destination index.
- wr1_data, input, DATA_W, late-return write data.
- sb_set_en, input, 1, mark a register busy (long-latency op issued).
- sb_set_idx, input, ADDR_W, register index to mark busy.
- rd_idx, input, NRD*ADDR_W, packed read indices; port i uses bits [i*ADDR_W +: ADDR_W].
- rd_data, output, NRD*DATA_W, packed read data, combinational.
- rd_busy, output, NRD, per-port hazard flag, combinational.
- busy_vec, output, NUM_REGS, registered scoreboard state.

Behaviour:
- Reset: one clk edge with rst=0 clears all registers to 0 and all busy_vec bits to 0.
  - Writes and sb_set requests in that cycle are ignored.
  - From the next cycle, rd_data = 0 and rd_busy = 0 for every port.
- Write arbitration, applied at the clock edge:
  - Only wr0 enabled: registers[wr0_idx] <= wr0_data. Only wr1 enabled: registers[wr1_idx] <= wr1_data.
  - Both enabled, different indices: both writes commit.
  - Both enabled, same index: wr0 wins, wr1 data is dropped. The busy bit is still cleared per the scoreboard rules.
  - ZERO_REG=1: any write to index 0 is discarded; register 0 stays 0.
  - No enable active: registers hold their value.
- Scoreboard, next-state rules per index k:
  - set  = sb_set_en && sb_set_idx==k
  - clr  = wr1_en && wr1_idx==k
  - set && clr: busy[k] <= 1 (the new issue wins).
  - set only: busy[k] <= 1. clr only: busy[k] <= 0. Neither: hold.
  - wr0 never changes busy bits.
  - ZERO_REG=1: busy[0] is forced to 0 at all times.
  - Setting a bit that is already set is legal and idempotent; there is no counting.
- Read data, combinational, per port i:
  - ZERO_REG=1 and idx==0: rd_data = 0.
  - BYPASS=1: if wr0_en && wr0_idx==idx, return wr0_data. Otherwise, if wr1_en && wr1_idx==idx, return wr1_data. Otherwise return registers[idx]. Priority matches write arbitration.
  - BYPASS=0: return registers[idx]. Written data becomes visible one cycle after the write.
- Read hazard, combinational, per port i:
  - BYPASS=1: rd_busy = busy_vec[idx] && !(wr1_en && wr1_idx==idx). The returning data is forwarded, so no stall.
  - BYPASS=0: rd_busy = busy_vec[idx] || (wr1_en && wr1_idx==idx).
  - ZERO_REG=1 and idx==0: rd_busy = 0.
  - An sb_set in the same cycle does not affect rd_busy until the next cycle.
- Latency: write-to-read is 0 cycles with BYPASS=1 and 1 cycle with BYPASS=0. Scoreboard set-to-visible is 1 cycle.
- Reset mid-operation: rst=0 overrides all writes and sets. Busy bits from in-flight operations are lost; the core flushes them.
- Combinational read paths must not depend on rst.

Test Plan:
- Reset, then read all 32 indices on both ports → all rd_data=0, rd_busy=0, busy_vec=0.
- wr0 writes 0xDEADBEEF to x5 while port0 reads x5 (BYPASS=1) → same cycle rd_data0=0xDEADBEEF; next cycle the stored value is still 0xDEADBEEF. Repeat with BYPASS=0 → 0 in the write cycle, 0xDEADBEEF in the next.
- wr0 writes 0x11 and wr1 writes 0x22, both to x7, in one cycle → x7 reads 0x11 afterwards. Write 0x33 to x0 → x0 reads 0.
- sb_set x9, next cycle read x9 → rd_busy=1. Then wr1 writes 0xCAFE to x9 → same cycle rd_busy=0 and rd_data=0xCAFE (BYPASS=1). Next cycle busy_vec[9]=0.
- sb_set x12 and wr1 to x12 in the same cycle → busy_vec[12]=1 next cycle. sb_set x0 → busy_vec[0] stays 0.
- Set x3, x4 busy and write x3=0x55, then assert rst=0 for one cycle together with wr0 to x3 → x3=0, busy_vec=0 after reset; the wr0 write is ignored.
